m_uart_loader: RTL and testbench

UART program loader that receives a length-prefixed binary image over a serial line and writes it, one 32-bit word per write, into a 4K-word memory through its write port (12-bit word address, write enable, 32-bit data). The processor only reads that memory. This block is the writer side: it drives the instruction/data memory write port and holds the processor in reset until the image has been loaded.

---
 rtl/m_uart_loader_pkg.sv | 23 ++
 rtl/m_uart_rx.sv | 80 ++++++++
 rtl/m_uart_loader.sv | 109 ++++++++++
 tb/tb_m_uart_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_uart_loader_pkg.sv
// rtl/m_uart_loader_pkg.sv - shared encodings and widths for the UART image loader
package m_uart_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 13;

  typedef enum logic [1:0] {
    S_LEN_HI = 2'd0,
    S_LEN_LO = 2'd1,
    S_DATA   = 2'd2,
    S_DONE   = 2'd3
  } load_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/m_uart_rx.sv
// rtl/m_uart_rx.sv - 8N1 UART byte receiver with glitch rejection and framing error
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       valid,
  output logic [7:0] data,
  output logic       ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic            s1, s2;
  rx_state_t       state, nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      sh;
  logic            tick_half, tick_full;

  assign tick_half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign tick_full = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      RX_IDLE:  if (!s2) nxt = RX_START;
      RX_START: if (tick_half) nxt = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) nxt = RX_STOP;
      RX_STOP:  if (tick_full) nxt = s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (s2) nxt = RX_IDLE;
      default:  nxt = RX_IDLE;
    endcase
  end

  // Counter restarts at mid-start-bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      if (state == RX_IDLE || state == RX_WAIT ||
          (state == RX_START && tick_half) || tick_full)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == RX_IDLE) bit_idx <= '0;
      if (state == RX_DATA && tick_full) begin
        sh      <= {s2, sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    valid = (state == RX_STOP) && tick_full && s2;
    ferr  = (state == RX_STOP) && tick_full && !s2;
    data  = sh;
  end

endmodule

// File: rtl/m_uart_loader.sv
// rtl/m_uart_loader.sv - loads a length-prefixed word image from UART into program memory
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORDS_MAX    = 4096
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdata,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  logic        bv, fe;
  logic [7:0]  bdata;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (w_clk),
    .rst   (w_rst),
    .rxd   (w_rxd),
    .valid (bv),
    .data  (bdata),
    .ferr  (fe)
  );

  load_state_t      state, nxt;
  logic [7:0]       len_hi;
  logic [15:0]      len, len_in;
  logic             len_bad;
  logic [1:0]       bidx;
  logic [IDX_W-1:0] widx;
  logic [23:0]      sh;
  logic             last_word;

  assign len_in    = {len_hi, bdata};
  assign last_word = ({3'b000, widx} == len - 16'd1);

  always_ff @(posedge w_clk) begin
    if (w_rst) state <= S_LEN_HI;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_LEN_HI: if (bv) nxt = S_LEN_LO;
      S_LEN_LO: if (bv) nxt = (len_in == 16'd0 || len_in > 16'(WORDS_MAX)) ? S_DONE : S_DATA;
      S_DATA:   if (bv && bidx == 2'd3 && last_word) nxt = S_DONE;
      default:  nxt = S_DONE;
    endcase
  end

  // Bytes accumulate in sh; r_wdata only changes when a full word is written.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      len_hi  <= '0;
      len     <= '0;
      len_bad <= 1'b0;
      bidx    <= '0;
      widx    <= '0;
      sh      <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (fe) r_err <= 1'b1;
      if (bv) begin
        case (state)
          S_LEN_HI: len_hi <= bdata;
          S_LEN_LO: begin
            len  <= len_in;
            bidx <= '0;
            widx <= '0;
            if (len_in > 16'(WORDS_MAX)) begin
              len_bad <= 1'b1;
              r_err   <= 1'b1;
            end
          end
          S_DATA: begin
            if (bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= widx[ADDR_W-1:0];
              r_wdata <= {sh, bdata};
              widx    <= widx + 1'b1;
              bidx    <= '0;
            end else begin
              sh   <= {sh[15:0], bdata};
              bidx <= bidx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    r_busy = (state != S_DONE);
    r_done = (state == S_DONE) && !len_bad;
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// tb/tb_m_uart_loader.sv - directed self-checking bench for m_uart_loader
module tb_m_uart_loader;

  localparam int CPB = 16;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_rxd = 1'b1;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_busy, r_done, r_err;

  int total = 0;
  int bad   = 0;

  int          we_cnt = 0;
  logic [11:0] a_log [4];
  logic [31:0] d_log [4];
  logic        done_log [4];
  logic        busy_log [4];

  m_uart_loader #(.CLKS_PER_BIT(CPB), .WORDS_MAX(4096)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_rxd   (w_rxd),
    .r_we    (r_we),
    .r_addr  (r_addr),
    .r_wdata (r_wdata),
    .r_busy  (r_busy),
    .r_done  (r_done),
    .r_err   (r_err)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) begin
    if (r_we) begin
      if (we_cnt < 4) begin
        a_log[we_cnt]    = r_addr;
        d_log[we_cnt]    = r_wdata;
        done_log[we_cnt] = r_done;
        busy_log[we_cnt] = r_busy;
      end
      we_cnt = we_cnt + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    we_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    w_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      idle(CPB);
    end
    w_rxd = stop;
    idle(CPB);
    w_rxd = 1'b1;
    idle(4);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    w_rxd = 1'b1;
    w_rst = 1'b1;
    idle(3);
    total++; if (r_we !== 1'b0)     begin bad++; $display("FAIL rst_we: got=%b expected=0", r_we); end
    total++; if (r_addr !== 12'h0)  begin bad++; $display("FAIL rst_addr: got=%h expected=000", r_addr); end
    total++; if (r_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got=%h expected=0", r_wdata); end
    total++; if (r_busy !== 1'b1)   begin bad++; $display("FAIL rst_busy: got=%b expected=1", r_busy); end
    total++; if (r_done !== 1'b0)   begin bad++; $display("FAIL rst_done: got=%b expected=0", r_done); end
    total++; if (r_err !== 1'b0)    begin bad++; $display("FAIL rst_err: got=%b expected=0", r_err); end
    w_rst = 1'b0;
    we_cnt = 0;
  endtask

  task automatic test_two_words();
    logic [7:0] img [10];
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
    idle(10);
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL img_we_count: got=%0d expected=2", we_cnt); end
    if (we_cnt >= 2) begin
      total++; if (a_log[0] !== 12'd0)        begin bad++; $display("FAIL img_addr0: got=%h expected=000", a_log[0]); end
      total++; if (d_log[0] !== 32'h12345678) begin bad++; $display("FAIL img_data0: got=%h expected=12345678", d_log[0]); end
      total++; if (done_log[0] !== 1'b0)      begin bad++; $display("FAIL img_done_at_w0: got=%b expected=0", done_log[0]); end
      total++; if (a_log[1] !== 12'd1)        begin bad++; $display("FAIL img_addr1: got=%h expected=001", a_log[1]); end
      total++; if (d_log[1] !== 32'h9ABCDEF0) begin bad++; $display("FAIL img_data1: got=%h expected=9abcdef0", d_log[1]); end
      total++; if (done_log[1] !== 1'b1)      begin bad++; $display("FAIL img_done_at_w1: got=%b expected=1", done_log[1]); end
      total++; if (busy_log[1] !== 1'b0)      begin bad++; $display("FAIL img_busy_at_w1: got=%b expected=0", busy_log[1]); end
    end
    total++; if (r_err !== 1'b0)           begin bad++; $display("FAIL img_err: got=%b expected=0", r_err); end
    total++; if (r_wdata !== 32'h9ABCDEF0) begin bad++; $display("FAIL img_wdata_hold: got=%h expected=9abcdef0", r_wdata); end
    send_byte(8'h55, 1'b1);
    idle(4);
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL done_ignores_bytes: got=%0d expected=2", we_cnt); end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b1);
    total++; if (r_done !== 1'b0) begin bad++; $display("FAIL zero_done_early: got=%b expected=0", r_done); end
    send_byte(8'h00, 1'b1);
    total++; if (r_done !== 1'b1) begin bad++; $display("FAIL zero_done: got=%b expected=1", r_done); end
    total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got=%b expected=0", r_busy); end
    total++; if (r_err !== 1'b0)  begin bad++; $display("FAIL zero_err: got=%b expected=0", r_err); end
    total++; if (we_cnt !== 0)    begin bad++; $display("FAIL zero_we_count: got=%0d expected=0", we_cnt); end
  endtask

  task automatic test_too_long();
    do_reset();
    send_byte(8'h10, 1'b1);
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1);
    total++; if (r_err !== 1'b1)  begin bad++; $display("FAIL long_err: got=%b expected=1", r_err); end
    total++; if (r_done !== 1'b0) begin bad++; $display("FAIL long_done: got=%b expected=0", r_done); end
    total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL long_busy: got=%b expected=0", r_busy); end
    total++; if (we_cnt !== 0)    begin bad++; $display("FAIL long_we_count: got=%0d expected=0", we_cnt); end
  endtask

  task automatic test_bad_stop();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(8);
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL stop_err: got=%b expected=1", r_err); end
    total++; if (we_cnt !== 0)   begin bad++; $display("FAIL stop_we_early: got=%0d expected=0", we_cnt); end
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(4);
    total++; if (we_cnt !== 1) begin bad++; $display("FAIL stop_we_count: got=%0d expected=1", we_cnt); end
    if (we_cnt >= 1) begin
      total++; if (d_log[0] !== 32'h11224455) begin bad++; $display("FAIL stop_data0: got=%h expected=11224455", d_log[0]); end
    end
    total++; if (r_done !== 1'b1) begin bad++; $display("FAIL stop_done: got=%b expected=1", r_done); end
  endtask

  task automatic test_glitch();
    do_reset();
    idle(2);
    w_rxd = 1'b0;
    idle(1);
    w_rxd = 1'b1;
    idle(40);
    total++; if (r_err !== 1'b0)  begin bad++; $display("FAIL glitch_err: got=%b expected=0", r_err); end
    total++; if (r_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got=%b expected=1", r_busy); end
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(4);
    total++; if (we_cnt !== 1) begin bad++; $display("FAIL glitch_we_count: got=%0d expected=1", we_cnt); end
    if (we_cnt >= 1) begin
      total++; if (d_log[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL glitch_data0: got=%h expected=deadbeef", d_log[0]); end
    end
    total++; if (r_done !== 1'b1) begin bad++; $display("FAIL glitch_done: got=%b expected=1", r_done); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] img [10];
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
    @(negedge w_clk);
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    total++; if (r_busy !== 1'b1)   begin bad++; $display("FAIL mid_busy: got=%b expected=1", r_busy); end
    total++; if (r_done !== 1'b0)   begin bad++; $display("FAIL mid_done: got=%b expected=0", r_done); end
    total++; if (r_addr !== 12'h0)  begin bad++; $display("FAIL mid_addr: got=%h expected=000", r_addr); end
    total++; if (r_wdata !== 32'h0) begin bad++; $display("FAIL mid_wdata: got=%h expected=0", r_wdata); end
    we_cnt = 0;
    for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
    idle(4);
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL mid_we_count: got=%0d expected=2", we_cnt); end
    if (we_cnt >= 2) begin
      chk("mid_addr0", {20'h0, a_log[0]}, 32'd0);
      chk("mid_data0", d_log[0], 32'h12345678);
      chk("mid_addr1", {20'h0, a_log[1]}, 32'd1);
      chk("mid_data1", d_log[1], 32'h9ABCDEF0);
    end
    total++; if (r_done !== 1'b1) begin bad++; $display("FAIL mid_done_end: got=%b expected=1", r_done); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_too_long();
    test_bad_stop();
    test_glitch();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
